// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a multicycle RV32I-subset datapath. One ALU and
// one memory are shared, so each instruction is spread over 3-5 cycles. A
// request/ready handshake can stretch any memory cycle.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high; forces FETCH
//   op            instruction[6:0] from IR
//   Zero          ALU zero flag (used in BEQ)
//   mem_ready     memory completes current access this cycle
//   mem_req       memory access requested (pure function of state)
//   MemWrite      store strobe, only together with mem_req
//   AdrSrc        memory address select: 0 PC, 1 ALUOut
//   IRWrite       latch instruction and OldPC
//   PCWrite       PC register enable
//   RegWrite      register file write enable
//   ResultSrc     00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA       00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB       00 rs2, 01 ImmExt, 10 constant 4
//   ALUOp         00 add, 01 sub/branch, 10 funct-decoded
//   ImmSrc        000 I, 001 S, 010 B, 011 J, 100 U (decoded from op only)
//   illegal_op    high while the FSM sits in TRAP
//   instr_retired one-cycle pulse when an instruction completes
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal_op,
  output logic       instr_retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_AUIPC    = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [3:0] state_reg;
  logic [3:0] state_next;

  // State register. Reset wins over any pending memory access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RESET_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Unused codes 14/15 fall through to FETCH.
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BEQ:            state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_TRAP;
        endcase
      end
      // op[5] separates stores (0100011) from loads (0000011).
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_LUI:      state_next = S_ALUWB;
      S_AUIPC:    state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // Output logic. Apart from the handshake-qualified enables in FETCH and
  // MEMWRITE and the branch decision in BEQ, outputs depend on state only.
  always_comb begin
    mem_req       = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    illegal_op    = 1'b0;
    instr_retired = 1'b0;
    case (state_reg)
      S_FETCH: begin
        // PC+4 is computed on the ALU and written straight from ALUResult.
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute OldPC+imm as branch/jump target.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req       = 1'b1;
        AdrSrc        = 1'b1;
        MemWrite      = 1'b1;
        instr_retired = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_ALUWB: begin
        ResultSrc     = 2'b00;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_BEQ: begin
        // Target already sits in ALUOut from DECODE; subtract sets Zero.
        ALUSrcA       = 2'b10;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b01;
        ResultSrc     = 2'b00;
        PCWrite       = Zero;
        instr_retired = 1'b1;
      end
      S_JAL: begin
        // PC <- target from ALUOut; ALU meanwhile forms OldPC+4 for rd.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b00;
        PCWrite   = 1'b1;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Immediate format select, decoded from the opcode alone.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:          ImmSrc = 3'b001;
      OP_BEQ:            ImmSrc = 3'b010;
      OP_JAL:            ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
      default:           ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Builds, per instruction, the expected cycle-by-cycle control vector from
// the instruction's phase list (fetch, decode, address, access, writeback)
// with random memory wait counts, then replays it against the controller.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       illegal_op, instr_retired;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       illegal;
    logic       retired;
  } outs_t;

  typedef struct {
    logic  rdy;
    logic  z;
    outs_t exp;
    string tag;
  } step_t;

  outs_t obs;
  assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op, instr_retired};

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  step_t plan[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    txn         = 0;

  function automatic logic [2:0] imm_of(input logic [6:0] opc);
    if (opc == OP_STORE) return 3'b001;
    if (opc == OP_BEQ)   return 3'b010;
    if (opc == OP_JAL)   return 3'b011;
    if (opc == OP_LUI || opc == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic outs_t base(input logic [6:0] opc);
    outs_t e;
    e = '0;
    e.imm_src = imm_of(opc);
    return e;
  endfunction

  task automatic push(input logic rdy, input logic z, input outs_t e, input string tag);
    step_t s;
    s.rdy = rdy; s.z = z; s.exp = e; s.tag = tag;
    plan.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(1, 0));
  endfunction

  // Instruction fetch: waits stall cycles, then the accepting cycle.
  task automatic ph_fetch(input logic [6:0] opc, input int waits);
    outs_t e;
    e = base(opc);
    e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    for (int i = 0; i < waits; i++) push(1'b0, rnd_bit(), e, "fetch_wait");
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b1, rnd_bit(), e, "fetch");
  endtask

  // Any cycle whose outputs do not depend on mem_ready: drive it randomly.
  task automatic ph_alu(input logic [6:0] opc, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] aop, input string tag);
    outs_t e;
    e = base(opc);
    e.alu_src_a = a; e.alu_src_b = b; e.alu_op = aop;
    push(rnd_bit(), rnd_bit(), e, tag);
  endtask

  task automatic ph_wb(input logic [6:0] opc, input logic [1:0] rsrc, input string tag);
    outs_t e;
    e = base(opc);
    e.result_src = rsrc; e.reg_write = 1'b1; e.retired = 1'b1;
    push(rnd_bit(), rnd_bit(), e, tag);
  endtask

  // Full expected trace of one instruction.
  task automatic plan_instr(input logic [6:0] opc, input int fw, input int mw, input logic z);
    outs_t e;
    ph_fetch(opc, fw);
    ph_alu(opc, 2'b01, 2'b01, 2'b00, "decode");
    case (opc)
      OP_LOAD: begin
        ph_alu(opc, 2'b10, 2'b01, 2'b00, "memadr");
        e = base(opc); e.mem_req = 1'b1; e.adr_src = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, rnd_bit(), e, "memread_wait");
        push(1'b1, rnd_bit(), e, "memread");
        ph_wb(opc, 2'b01, "memwb");
      end
      OP_STORE: begin
        ph_alu(opc, 2'b10, 2'b01, 2'b00, "memadr");
        e = base(opc); e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, rnd_bit(), e, "memwrite_wait");
        e.retired = 1'b1;
        push(1'b1, rnd_bit(), e, "memwrite");
      end
      OP_RTYPE: begin ph_alu(opc, 2'b10, 2'b00, 2'b10, "execr"); ph_wb(opc, 2'b00, "aluwb"); end
      OP_ITYPE: begin ph_alu(opc, 2'b10, 2'b01, 2'b10, "execi"); ph_wb(opc, 2'b00, "aluwb"); end
      OP_LUI:   begin ph_alu(opc, 2'b11, 2'b01, 2'b00, "lui");   ph_wb(opc, 2'b00, "aluwb"); end
      OP_AUIPC: begin ph_alu(opc, 2'b01, 2'b01, 2'b00, "auipc"); ph_wb(opc, 2'b00, "aluwb"); end
      OP_BEQ: begin
        e = base(opc); e.alu_src_a = 2'b10; e.alu_op = 2'b01;
        e.pc_write = z; e.retired = 1'b1;
        push(rnd_bit(), z, e, "beq");
      end
      OP_JAL: begin
        e = base(opc); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
        push(rnd_bit(), rnd_bit(), e, "jal");
        ph_wb(opc, 2'b00, "aluwb");
      end
      default: begin
        e = base(opc); e.illegal = 1'b1;
        for (int i = 0; i < 10; i++) push(rnd_bit(), rnd_bit(), e, "trap");
      end
    endcase
  endtask

  // Replay up to limit steps of the plan, then discard the rest.
  task automatic run_plan(input int limit);
    step_t s;
    int    n;
    n = 0;
    while (plan.size() > 0 && n < limit) begin
      s = plan.pop_front();
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = s.rdy;
      Zero      = s.z;
      #1;
      vectors++;
      assert (obs === s.exp) else begin
        miscompares++;
        $error("FAIL %s op=%b: observed %h expected %h", s.tag, op, obs, s.exp);
      end
      n++;
    end
    plan.delete();
    txn++;
    $display("txn %0d op=%b cycles=%0d", txn, op, n);
  endtask

  task automatic do_instr(input logic [6:0] opc, input int fw, input int mw, input logic z);
    op = opc;
    plan_instr(opc, fw, mw, z);
    run_plan(1000);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = rnd_bit();
    Zero      = rnd_bit();
    @(posedge clk);
  endtask

  logic [6:0] legal_ops [8];

  initial begin
    reset = 1'b1; mem_ready = 1'b0; Zero = 1'b0; op = OP_RTYPE;
    legal_ops[0] = OP_LOAD;  legal_ops[1] = OP_STORE; legal_ops[2] = OP_RTYPE;
    legal_ops[3] = OP_ITYPE; legal_ops[4] = OP_BEQ;   legal_ops[5] = OP_JAL;
    legal_ops[6] = OP_LUI;   legal_ops[7] = OP_AUIPC;
    repeat (2) @(posedge clk);

    // Directed: reset state seen in the first fetch wait, then each class.
    do_instr(OP_RTYPE, 1, 0, 1'b0);
    do_instr(OP_LOAD,  0, 2, 1'b0);
    do_instr(OP_STORE, 0, 1, 1'b0);
    do_instr(OP_BEQ,   0, 0, 1'b1);
    do_instr(OP_BEQ,   0, 0, 1'b0);
    do_instr(OP_JAL,   0, 0, 1'b0);
    do_instr(OP_LUI,   0, 0, 1'b0);
    do_instr(OP_AUIPC, 0, 0, 1'b0);
    do_instr(OP_ITYPE, 2, 0, 1'b0);

    // Random instruction stream with random wait states.
    for (int k = 0; k < 40; k++) begin
      do_instr(legal_ops[$urandom_range(7, 0)], $urandom_range(3, 0),
               $urandom_range(3, 0), rnd_bit());
    end

    // Reset in the middle of a MEMREAD stall.
    op = OP_LOAD;
    plan_instr(OP_LOAD, 0, 5, 1'b0);
    run_plan(5);
    apply_reset();
    plan_instr(OP_LOAD, 1, 0, 1'b0);
    run_plan(1);

    // Illegal opcode: TRAP held 10 cycles, then reset out of it.
    do_instr(OP_BAD, 0, 0, 1'b0);
    apply_reset();
    do_instr(OP_RTYPE, 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a shared-ALU, shared-memory multicycle RISC-V (RV32I subset) datapath.
- Replaces the single-cycle decode path; one instruction takes 3–5 cycles plus memory wait cycles.
- Drives mux selects, register/IR/PC write enables and a request/ready memory handshake. ALUOp feeds the existing ALU decoder.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset; the encoding is fixed below.

Ports:
- clk input 1: clock, rising edge.
- reset input 1: synchronous, active-high.
- op input 7: instruction[6:0] from IR.
- Zero input 1: ALU zero flag.
- mem_ready input 1: memory completes the current access this cycle.
- mem_req output 1: memory access requested.
- MemWrite output 1: store strobe, valid only while mem_req=1.
- AdrSrc output 1: 0 = PC, 1 = ALUOut as memory address.
- IRWrite output 1: latch instruction and OldPC.
- PCWrite output 1: PC register enable.
- RegWrite output 1: register file write.
- ResultSrc output 2: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA output 2: 00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB output 2: 00 rs2, 01 ImmExt, 10 constant 4.
- ALUOp output 2: 00 add, 01 sub/branch, 10 funct-decoded.
- ImmSrc output 3: 000 I, 001 S, 010 B, 011 J, 100 U; combinational from op only.
- illegal_op output 1: sticky, high in TRAP.
- instr_retired output 1: one-cycle pulse at instruction completion.

Behaviour:
- States (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11, AUIPC 12, TRAP 13. Codes 14–15 go to FETCH.
- reset=1 at a clock edge puts state in FETCH regardless of current state, including mid-access. Reset does not wait for mem_ready.
- Reset values of outputs are the FETCH values: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite are 0 unless mem_ready=1. All other enables are 0, illegal_op=0 and instr_retired=0.
- Every output not listed for a state is 0 / 00.
- FETCH:
  - Outputs: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while !mem_ready; otherwise goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
  - Next state by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; 0110111 → LUI; 0010111 → AUIPC; any other op → TRAP.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01.
  - Next: op[5]=0 → MEMREAD, else → MEMWRITE.
- MEMREAD:
  - Outputs: mem_req, AdrSrc=1.
  - Holds while !mem_ready, then → MEMWB.
- MEMWB:
  - Outputs: ResultSrc=01, RegWrite, instr_retired.
  - Next: FETCH.
- MEMWRITE:
  - Outputs: mem_req, AdrSrc=1, MemWrite.
  - Holds while !mem_ready. When mem_ready: instr_retired=1, → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; → ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01; → ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01; → ALUWB.
- ALUWB: ResultSrc=00, RegWrite, instr_retired; → FETCH.
- BEQ:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = Zero (combinational); instr_retired=1.
  - Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1; → ALUWB (writes PC+4 to rd).
- TRAP:
  - Outputs: illegal_op=1, all enables 0, mem_req=0.
  - Stays in TRAP until reset.
- Latency with zero wait states:
  - R/I/LUI/AUIPC/JAL: 4 cycles (JAL: FETCH, DECODE, JAL, ALUWB).
  - lw: 5 cycles.
  - sw and beq: 4 and 3 cycles.
  - Each cycle with mem_ready=0 in a mem_req state adds exactly one cycle.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- mem_req is a pure function of state, so memory may see an arbitrarily long request.
- Exactly one instr_retired pulse per completed instruction; none in TRAP.

Test Plan:
- Reset then add (op=0110011), mem_ready=1 → states 0,1,6,8,0. RegWrite only in cycle 4 with ResultSrc=00, ALUOp=10 in EXECR, one instr_retired pulse.
- lw (0000011) with mem_ready low for 2 cycles in MEMREAD → 0,1,2,3,3,3,4,0. AdrSrc=1 throughout MEMREAD, RegWrite with ResultSrc=01.
- sw (0100011) → MemWrite=1 only in MEMWRITE with mem_req=1, RegWrite never asserted, instr_retired on the mem_ready cycle.
- beq run twice, with Zero=1 and then Zero=0 in BEQ → PCWrite=1 and then 0 in that cycle. Both runs take 3 cycles and return to FETCH.
- jal (1101111) → PCWrite in FETCH and JAL, then RegWrite in ALUWB. lui → ALUSrcA=11; auipc → ALUSrcA=01.
- op=1111111 → TRAP with illegal_op=1 held for 10 cycles and no enables. Assert reset for 1 cycle mid-MEMREAD stall and mid-TRAP → FETCH next cycle, illegal_op=0.
